// File: rtl/tst_din_pkg.sv
// Shared types, constants and helpers for the tst_din_gen frame generator.
// The PRBS helpers are only referenced when TST_DIN_PRBS_EN is defined.
package tst_din_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STREAM,
        ST_DONE
    } state_e;

    localparam int SAMPLE_W            = 32;
    localparam int HALF_W              = 16;
    localparam int DEFAULT_FRAME_BEATS = 1024;

    // PRBS-31, x^31 + x^28 + 1: feedback taps on state bits 30 and 27.
    localparam int                PRBS_W        = 31;
    localparam logic [PRBS_W-1:0] PRBS_TAPS     = 31'h4800_0000;
    localparam logic [31:0]       PRBS_LANE_MIX = 32'h9E37_79B9;

    typedef struct packed {
        logic [PRBS_W-1:0]   state;
        logic [SAMPLE_W-1:0] bits;
    } prbs_t;

    function automatic int lane_lsb(input int lane);
        return lane * SAMPLE_W;
    endfunction

    function automatic logic [SAMPLE_W-1:0] sample_pack(input logic [HALF_W-1:0] re,
                                                        input logic [HALF_W-1:0] im);
        return {im, re};
    endfunction

    // A seed whose 31 register bits are all zero would lock the LFSR, so it becomes 1.
    function automatic logic [PRBS_W-1:0] prbs_seed(input logic [31:0] nite, input int lane);
        logic [PRBS_W-1:0] s;
        s = PRBS_W'(nite ^ (32'(lane) * PRBS_LANE_MIX));
        if (s == '0) s = PRBS_W'(1);
        return s;
    endfunction

    // Runs the LFSR 32 steps; bit i of the result is the i-th new bit produced.
    function automatic prbs_t prbs_step32(input logic [PRBS_W-1:0] state);
        prbs_t r;
        logic  fb;
        r.state = state;
        r.bits  = '0;
        for (int i = 0; i < SAMPLE_W; i++) begin
            fb        = ^(r.state & PRBS_TAPS);
            r.bits[i] = fb;
            r.state   = {r.state[PRBS_W-2:0], fb};
        end
        return r;
    endfunction

endpackage

// File: rtl/tst_din_lane.sv
// One sample lane of tst_din_gen: supplies the sample for the beat being loaded.
// Ramp pattern by default; per-lane PRBS-31 LFSR when TST_DIN_PRBS_EN is defined.
module tst_din_lane
    import tst_din_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic [31:0]         seed,
`ifdef TST_DIN_PRBS_EN
    input  logic                clk,
    input  logic                srst_n,
    input  logic                load,
    input  logic                adv,
`else
    input  logic [15:0]         idx_base,
`endif
    output logic [SAMPLE_W-1:0] sample
);

`ifdef TST_DIN_PRBS_EN
    logic [PRBS_W-1:0] lfsr_q;
    prbs_t             step;

    // On load the first beat is generated straight from the seed, so it is ready in LOAD.
    always_comb begin
        step   = prbs_step32(load ? prbs_seed(seed, LANE) : lfsr_q);
        sample = step.bits;
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            lfsr_q <= PRBS_W'(1);
        end else if (load || adv) begin
            lfsr_q <= step.state;
        end
    end
`else
    logic [15:0] idx;

    always_comb begin
        idx    = idx_base + 16'(LANE);
        sample = sample_pack(idx + seed[15:0], seed[31:16] - idx);
    end
`endif

endmodule

// File: rtl/tst_din_gen.sv
// Test-stimulus frame generator: one start pulse emits one AXI4-Stream frame of
// seeded complex samples, then pulses done_o. TST_DIN_PRBS_EN selects PRBS lanes.
module tst_din_gen
    import tst_din_pkg::*;
#(
    parameter int NLANE       = 4,
    parameter int FRAME_BEATS = DEFAULT_FRAME_BEATS,
    parameter int BEAT_W      = 16
) (
    input  logic                      clk,
    input  logic                      srst_n,
    input  logic                      start_i,
    input  logic [31:0]               nite_i,
    output logic                      done_o,
    output logic                      busy_o,
    output logic                      start_ovr_o,
    output logic [31:0]               stall_cnt_o,
    output logic [SAMPLE_W*NLANE-1:0] m_axis_tdata,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast
);

    localparam int                DATA_W    = SAMPLE_W * NLANE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

    state_e            state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [31:0]       seed_q;
    logic [DATA_W-1:0] tdata_q, lane_data;
    logic              tvalid_q, tlast_q, ovr_q;
    logic [31:0]       stall_q;
    logic              accept, handshake, last_hs;
    logic              load_first, load_next, load_beat;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        accept     = (state_q == ST_IDLE) && start_i;
        handshake  = tvalid_q && m_axis_tready;
        last_hs    = (state_q == ST_STREAM) && handshake && (beat_q == LAST_BEAT);
        load_first = (state_q == ST_LOAD);
        load_next  = (state_q == ST_STREAM) && handshake && (beat_q != LAST_BEAT);
        load_beat  = load_first || load_next;
        beat_d     = load_first ? '0 : beat_q + BEAT_W'(1);

        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_STREAM;
            ST_STREAM: if (last_hs) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifndef TST_DIN_PRBS_EN
    logic [15:0] idx_base;
    assign idx_base = 16'(beat_d * NLANE);
`endif

    for (genvar k = 0; k < NLANE; k++) begin : g_lane
        tst_din_lane #(
            .LANE(k)
        ) u_lane (
            .seed     (seed_q),
`ifdef TST_DIN_PRBS_EN
            .clk      (clk),
            .srst_n   (srst_n),
            .load     (load_first),
            .adv      (load_next),
`else
            .idx_base (idx_base),
`endif
            .sample   (lane_data[lane_lsb(k) +: SAMPLE_W])
        );
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            seed_q   <= '0;
            beat_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovr_q    <= 1'b0;
            stall_q  <= '0;
        end else begin
            if (accept) begin
                seed_q  <= nite_i;
                beat_q  <= '0;
                stall_q <= '0;
            end else if (tvalid_q && !m_axis_tready && (stall_q != '1)) begin
                stall_q <= stall_q + 32'd1;
            end

            // A new beat replaces the accepted one in the same edge, so there are no bubbles.
            if (load_beat) begin
                tdata_q  <= lane_data;
                beat_q   <= beat_d;
                tvalid_q <= 1'b1;
                tlast_q  <= (beat_d == LAST_BEAT);
            end else if (last_hs) begin
                tvalid_q <= 1'b0;
                tlast_q  <= 1'b0;
            end

            if (start_i && (state_q != ST_IDLE)) begin
                ovr_q <= 1'b1;
            end
        end
    end

    assign busy_o        = (state_q != ST_IDLE);
    assign done_o        = (state_q == ST_DONE);
    assign start_ovr_o   = ovr_q;
    assign stall_cnt_o   = stall_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_tst_din_gen.sv
// Bench for tst_din_gen: directed frame scenarios with random seeds and tready,
// checked against a pattern model (ramp, or PRBS-31 when TST_DIN_PRBS_EN is defined).
module tb_tst_din_gen;

    localparam int NLANE       = 4;
    localparam int FRAME_BEATS = 1024;
    localparam int DW          = 32 * NLANE;
    localparam int BUDGET      = 8 * FRAME_BEATS + 64;

    logic          clk = 1'b0;
    logic          srst_n;
    logic          start_i;
    logic [31:0]   nite_i;
    logic          done_o;
    logic          busy_o;
    logic          start_ovr_o;
    logic [31:0]   stall_cnt_o;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_mem [FRAME_BEATS*NLANE];

    tst_din_gen #(
        .NLANE       (NLANE),
        .FRAME_BEATS (FRAME_BEATS),
        .BEAT_W      (16)
    ) dut (
        .clk           (clk),
        .srst_n        (srst_n),
        .start_i       (start_i),
        .nite_i        (nite_i),
        .done_o        (done_o),
        .busy_o        (busy_o),
        .start_ovr_o   (start_ovr_o),
        .stall_cnt_o   (stall_cnt_o),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pattern for a whole frame, derived directly from the sample rules.
    task automatic build_frame(input logic [31:0] seed);
`ifdef TST_DIN_PRBS_EN
        logic [31:0] mixed;
        logic [30:0] init;
        bit          x[];
        x = new[31 + 32*FRAME_BEATS];
        for (int k = 0; k < NLANE; k++) begin
            mixed = seed ^ (32'(k) * 32'h9E37_79B9);
            init  = mixed[30:0];
            if (init == 31'd0) init = 31'd1;
            for (int i = 0; i < 31; i++) x[i] = init[30-i];
            for (int n = 31; n < x.size(); n++) x[n] = x[n-31] ^ x[n-28];
            for (int b = 0; b < FRAME_BEATS; b++)
                for (int j = 0; j < 32; j++)
                    exp_mem[b*NLANE+k][j] = x[31 + 32*b + j];
        end
`else
        logic [15:0] idx;
        for (int b = 0; b < FRAME_BEATS; b++) begin
            for (int k = 0; k < NLANE; k++) begin
                idx = 16'((b*NLANE + k) % 65536);
                exp_mem[b*NLANE+k] = {seed[31:16] - idx, seed[15:0] + idx};
            end
        end
`endif
    endtask

    function automatic logic [DW-1:0] exp_beat(input int b);
        logic [DW-1:0] r;
        for (int k = 0; k < NLANE; k++) r[32*k +: 32] = exp_mem[b*NLANE+k];
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, "_tvalid"}, DW'(m_axis_tvalid), DW'(0));
        check({tag, "_tlast"},  DW'(m_axis_tlast),  DW'(0));
        check({tag, "_done"},   DW'(done_o),        DW'(0));
        check({tag, "_busy"},   DW'(busy_o),        DW'(0));
        check({tag, "_ovr"},    DW'(start_ovr_o),   DW'(0));
        check({tag, "_stall"},  DW'(stall_cnt_o),   DW'(0));
        check({tag, "_tdata"},  m_axis_tdata,       DW'(0));
    endtask

    // Called at posedge+1; returns at posedge+1.
    task automatic idle(input int n);
        start_i = 1'b0;
        repeat (n) begin
            @(negedge clk);
            check("idle_done", DW'(done_o), DW'(0));
            check("idle_busy", DW'(busy_o), DW'(0));
        end
        @(posedge clk); #1;
    endtask

    task automatic reset_mid_frame();
        srst_n        = 1'b0;
        start_i       = 1'b0;
        m_axis_tready = 1'($urandom_range(1, 0));
        @(posedge clk); #1;
        check_reset_state("rst_mid");
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_done",   DW'(done_o),        DW'(0));
            check("rst_hold_tvalid", DW'(m_axis_tvalid), DW'(0));
        end
        srst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Starts a frame from posedge+1 and follows it to done_o (or a planted reset).
    task automatic run_frame(input logic [31:0] seed, input bit rand_ready, input int ovr_beat,
                             input int rst_beat, output logic [DW-1:0] first_beat);
        int            beat = 0;
        int            cyc = 0;
        int            stalls = 0;
        int            busy_cnt = 0;
        int            first_valid = -1;
        bit            done_seen = 1'b0;
        bit            ovr_sent = 1'b0;
        bit            prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic          prev_last = 1'b0;

        build_frame(seed);
        first_beat = '0;
        start_i = 1'b1;
        nite_i  = seed;
        @(negedge clk);
        check("pre_accept_busy", DW'(busy_o), DW'(0));
        check("pre_accept_done", DW'(done_o), DW'(0));
        @(posedge clk); #1;
        start_i = 1'b0;
        nite_i  = $urandom;

        while (!done_seen && cyc < BUDGET) begin
            if (rst_beat >= 0 && beat == rst_beat) begin
                reset_mid_frame();
                return;
            end
            m_axis_tready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
            start_i = (ovr_beat >= 0) && (beat == ovr_beat) && !ovr_sent;
            if (start_i) begin
                ovr_sent = 1'b1;
                nite_i   = $urandom;
            end
            @(negedge clk);
            cyc++;
            if (busy_o) busy_cnt++;
            check("busy",   DW'(busy_o),        DW'(1));
            check("tvalid", DW'(m_axis_tvalid), DW'(cyc >= 2 && beat < FRAME_BEATS));
            check("done",   DW'(done_o),        DW'(beat == FRAME_BEATS));
            if (m_axis_tvalid && beat < FRAME_BEATS) begin
                if (first_valid < 0) first_valid = cyc;
                if (beat == 0) first_beat = m_axis_tdata;
                check("tdata", m_axis_tdata, exp_beat(beat));
                check("tlast", DW'(m_axis_tlast), DW'(beat == FRAME_BEATS-1));
                if (prev_stall) begin
                    check("stall_tdata_stable", m_axis_tdata,      prev_data);
                    check("stall_tlast_stable", DW'(m_axis_tlast), DW'(prev_last));
                end
                prev_stall = !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
                if (m_axis_tready) beat++;
                else stalls++;
            end
            if (done_o) done_seen = 1'b1;
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        check("frame_completed",     DW'(done_seen),   DW'(1));
        check("first_valid_latency", DW'(first_valid), DW'(2));
        check("busy_cycles",         DW'(busy_cnt),    DW'(FRAME_BEATS + 2 + stalls));
        check("stall_count",         DW'(stall_cnt_o), DW'(stalls));
    endtask

    initial begin
        logic [DW-1:0] fb;
        srst_n        = 1'b0;
        start_i       = 1'b0;
        nite_i        = '0;
        m_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        srst_n = 1'b1;
        @(posedge clk); #1;

        // Reference frame, tready held high.
        run_frame(32'h0003_0010, 1'b0, -1, -1, fb);
`ifndef TST_DIN_PRBS_EN
        check("beat0_lane0", DW'(fb[31:0]),   DW'(32'h0003_0010));
        check("beat0_lane3", DW'(fb[127:96]), DW'(32'h0000_0013));
`endif
        check("no_overrun", DW'(start_ovr_o), DW'(0));
        idle(3);

        // Same seed with 50% tready.
        run_frame(32'h0003_0010, 1'b1, -1, -1, fb);
        idle(2);

        // Start while busy at beat 500: ignored, flagged, single done.
        run_frame(32'h0003_0010, 1'b0, 500, -1, fb);
        check("overrun_set", DW'(start_ovr_o), DW'(1));
        idle(5);
        check("overrun_sticky", DW'(start_ovr_o), DW'(1));

        // Back-to-back: second start in the cycle right after done_o.
        run_frame($urandom, 1'b1, -1, -1, fb);
        run_frame(32'h0000_0001, 1'b0, -1, -1, fb);
`ifndef TST_DIN_PRBS_EN
        check("b2b_beat0_lane0", DW'(fb[31:0]), DW'(32'h0000_0001));
`endif
        check("overrun_still_set", DW'(start_ovr_o), DW'(1));
        idle(2);

        // Reset at beat 300, then a fresh full frame.
        run_frame($urandom, 1'b0, -1, 300, fb);
        check("overrun_cleared", DW'(start_ovr_o), DW'(0));
        run_frame($urandom, 1'b1, -1, -1, fb);
        idle(2);

        // Random seeds with random gaps.
        repeat (2) begin
            run_frame($urandom, 1'b1, -1, -1, fb);
            idle($urandom_range(3, 0));
        end

`ifdef TST_DIN_PRBS_EN
        // nite_i = 0 forces lane 0's seed to 1.
        run_frame(32'h0000_0000, 1'b1, -1, -1, fb);
        check("prbs_lane0_zero_seed", DW'(fb[31:0]), DW'(exp_mem[0]));
        idle(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
